// File: rtl/compare_search.sv
// Successive-approximation search driving an external magnitude comparator.
// Define COMPARE_SEARCH_EARLY_EXIT_EN to stop as soon as the comparator reports equality.
module compare_search #(
  parameter int NrOfBits       = 8,
  parameter int TwosComplement = 1,
  parameter int SampleDelay    = 0
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Start,
  input  logic                CmpEq,
  input  logic                CmpGt,
  input  logic                CmpLt,
  output logic [NrOfBits-1:0] Probe,
  output logic [NrOfBits-1:0] Result,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic [7:0]          StepCount
);

  localparam int IW = (NrOfBits > 2) ? $clog2(NrOfBits) : 1;
  localparam logic [3:0] SAMPLE_LAST = 4'(SampleDelay);
  localparam logic [NrOfBits-1:0] ONE = {{(NrOfBits-1){1'b0}}, 1'b1};
  // The search runs in offset binary; flipping the MSB turns it into two's complement.
  localparam logic [NrOfBits-1:0] MAP_MASK =
    (TwosComplement != 0) ? {1'b1, {(NrOfBits-1){1'b0}}} : {NrOfBits{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [NrOfBits-1:0] map_f(input logic [NrOfBits-1:0] x);
    return x ^ MAP_MASK;
  endfunction

  state_e              state_q, state_d;
  logic [NrOfBits-1:0] u_q, u_d;
  logic [IW-1:0]       i_q, i_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NrOfBits-1:0] result_q, result_d;
  logic [NrOfBits-1:0] probe_q, probe_d;
  logic [7:0]          step_q, step_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NrOfBits-1:0] trial_s;
  logic [NrOfBits-1:0] kept_s;
  logic                onehot_s;
  logic                sample_s;
  logic                early_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    i_d      = i_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    step_d   = step_q;
    error_d  = error_q;

    trial_s  = u_q | (ONE << i_q);
    kept_s   = CmpLt ? u_q : trial_s;
    onehot_s = ({CmpEq, CmpGt, CmpLt} == 3'b100) ||
               ({CmpEq, CmpGt, CmpLt} == 3'b010) ||
               ({CmpEq, CmpGt, CmpLt} == 3'b001);
    sample_s = (cnt_q == SAMPLE_LAST);
`ifdef COMPARE_SEARCH_EARLY_EXIT_EN
    early_s  = CmpEq;
`else
    early_s  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          u_d     = {NrOfBits{1'b0}};
          i_d     = IW'(NrOfBits - 1);
          cnt_d   = 4'd0;
          step_d  = 8'd0;
          error_d = 1'b0;
          state_d = PROBE;
        end else begin
          state_d = IDLE;
        end
      end
      PROBE: begin
        if (!sample_s) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!onehot_s) begin
          // A broken comparator aborts without applying the bit under test.
          cnt_d    = 4'd0;
          error_d  = 1'b1;
          result_d = map_f(u_q);
          state_d  = DONE;
        end else if (early_s) begin
          cnt_d    = 4'd0;
          step_d   = step_q + 8'd1;
          u_d      = trial_s;
          result_d = map_f(trial_s);
          state_d  = DONE;
        end else begin
          cnt_d  = 4'd0;
          step_d = step_q + 8'd1;
          u_d    = kept_s;
          if (i_q == {IW{1'b0}}) begin
            result_d = map_f(kept_s);
            state_d  = DONE;
          end else begin
            i_d = i_q - IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == PROBE) begin
      probe_d = map_f(u_d | (ONE << i_d));
    end else begin
      probe_d = map_f(u_d);
    end
    busy_d = (state_d == PROBE);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      u_q      <= {NrOfBits{1'b0}};
      i_q      <= {IW{1'b0}};
      cnt_q    <= 4'd0;
      result_q <= {NrOfBits{1'b0}};
      probe_q  <= {NrOfBits{1'b0}};
      step_q   <= 8'd0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      i_q      <= i_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      probe_q  <= probe_d;
      step_q   <= step_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Probe     = probe_q;
  assign Result    = result_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign StepCount = step_q;

endmodule
